// File: rtl/goertzel_tone_gen_if.sv
// Sample stream of the Goertzel tone generator: valid/ready handshake plus 32.32 sample data.
interface goertzel_tone_gen_if #(
  parameter int unsigned DW = 64
) ();
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] data_o;

  modport master (output valid_o, output data_o, input ready_i);
  modport slave  (input valid_o, input data_o, output ready_i);
endinterface

// File: rtl/goertzel_tone_gen.sv
// Goertzel resonator sinusoid generator: emits ns samples y[n] = A*sin((n+1)*w), one per two cycles,
// using y[n+1] = sat(((2cos(w) * y[n]) >>> FRAC) - y[n-1]).
module goertzel_tone_gen #(
  parameter int unsigned DW   = 64,
  parameter int unsigned FRAC = 32,
  parameter int unsigned NSW  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NSW-1:0]  ns_i,
  input  logic [DW-1:0]   alpha_i,
  input  logic [DW-1:0]   init_i,
  output logic            busy,
  output logic            done,
  goertzel_tone_gen_if.master strm
);

  typedef enum logic [1:0] {StIdle, StEmit, StStep, StDone} state_e;

  state_e          state_q, state_d;
  logic [NSW-1:0]  ns_q, ns_d;
  logic [NSW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]   alpha_q, alpha_d;
  logic [DW-1:0]   y_cur_q, y_cur_d;
  logic [DW-1:0]   y_prev_q, y_prev_d;

  logic signed [2*DW-1:0] a_ext, y_ext, prod;
  logic [DW+FRAC:0]       diff;
  logic [DW+FRAC:DW-1]    diff_top;
  logic [DW-1:0]          y_next;
  logic                   prod_frac_unused;

  // Recurrence datapath: the product's low FRAC bits drop out of the floor shift, and the
  // top DW+FRAC+1 bits hold the shifted product plus headroom for the subtraction.
  always_comb begin
    a_ext    = {{DW{alpha_q[DW-1]}}, alpha_q};
    y_ext    = {{DW{y_cur_q[DW-1]}}, y_cur_q};
    prod     = a_ext * y_ext;
    diff     = {prod[2*DW-1], prod[2*DW-1:FRAC]}
             - {{(FRAC + 1){y_prev_q[DW-1]}}, y_prev_q};
    diff_top = diff[DW+FRAC:DW-1];
    if ((&diff_top) || !(|diff_top)) begin
      y_next = diff[DW-1:0];
    end else if (diff[DW+FRAC]) begin
      y_next = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      y_next = {1'b0, {(DW - 1){1'b1}}};
    end
  end

  assign prod_frac_unused = ^prod[FRAC-1:0];

  always_comb begin
    state_d  = state_q;
    ns_d     = ns_q;
    cnt_d    = cnt_q;
    alpha_d  = alpha_q;
    y_cur_d  = y_cur_q;
    y_prev_d = y_prev_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          alpha_d  = alpha_i;
          ns_d     = ns_i;
          y_cur_d  = init_i;
          y_prev_d = '0;
          cnt_d    = '0;
          state_d  = (ns_i == '0) ? StDone : StEmit;
        end
      end
      StEmit: begin
        if (strm.ready_i) begin
          // Compare against ns-1 so ns = 2^NSW-1 finishes without the counter wrapping.
          if (cnt_q == ns_q - NSW'(1)) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + NSW'(1);
            state_d = StStep;
          end
        end
      end
      StStep: begin
        y_prev_d = y_cur_q;
        y_cur_d  = y_next;
        state_d  = StEmit;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ns_q     <= '0;
      cnt_q    <= '0;
      alpha_q  <= '0;
      y_cur_q  <= '0;
      y_prev_q <= '0;
    end else begin
      state_q  <= state_d;
      ns_q     <= ns_d;
      cnt_q    <= cnt_d;
      alpha_q  <= alpha_d;
      y_cur_q  <= y_cur_d;
      y_prev_q <= y_prev_d;
    end
  end

  // All outputs decode registered state only; ready has no combinational path to them.
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign strm.valid_o = (state_q == StEmit);
  assign strm.data_o  = y_cur_q;

endmodule
